// File: rtl/exu_mdu_ysyx_23060136.sv
`default_nettype none
// ============================================================================
// exu_mdu_ysyx_23060136 : iterative RV32M multiply/divide unit (1 bit/cycle)
// Rev 1.0
// ============================================================================
module exu_mdu_ysyx_23060136 (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXU_MDU_valid,
    output logic        EXU_MDU_ready,
    input  logic [2:0]  EXU_MDU_op,
    input  logic [31:0] EXU_HAZARD_rs1_data,
    input  logic [31:0] EXU_HAZARD_rs2_data,
    input  logic        EXU_MDU_flush,
    output logic [31:0] EXU_MDU_result,
    output logic        EXU_MDU_result_valid,
    input  logic        EXU_MDU_result_ready
);
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [63:0] acc, acc_nx;
    logic [4:0]  cnt;
    logic [31:0] fix_result;

    logic        accept, in_div, in_sa, in_sb, a_neg, b_neg;
    logic        div_zero, div_ovf, fast;
    logic [31:0] mag_a_in, mag_b_in, fast_result;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic [63:0] prod;

    assign EXU_MDU_ready = (state == IDLE);
    assign accept = EXU_MDU_valid && EXU_MDU_ready && !EXU_MDU_flush;

    always_comb begin
        in_div   = EXU_MDU_op[2];
        in_sa    = (EXU_MDU_op == 3'b001) || (EXU_MDU_op == 3'b010) ||
                   (EXU_MDU_op == 3'b100) || (EXU_MDU_op == 3'b110);
        in_sb    = (EXU_MDU_op == 3'b001) || (EXU_MDU_op == 3'b100) ||
                   (EXU_MDU_op == 3'b110);
        a_neg    = in_sa && EXU_HAZARD_rs1_data[31];
        b_neg    = in_sb && EXU_HAZARD_rs2_data[31];
        mag_a_in = a_neg ? (~EXU_HAZARD_rs1_data + 32'd1) : EXU_HAZARD_rs1_data;
        mag_b_in = b_neg ? (~EXU_HAZARD_rs2_data + 32'd1) : EXU_HAZARD_rs2_data;
        div_zero = in_div && (EXU_HAZARD_rs2_data == 32'd0);
        div_ovf  = in_div && !EXU_MDU_op[0] && (EXU_HAZARD_rs1_data == INT_MIN) &&
                   (EXU_HAZARD_rs2_data == ALL_ONES);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_result = EXU_MDU_op[1] ? EXU_HAZARD_rs1_data : ALL_ONES;
        else
            fast_result = EXU_MDU_op[1] ? 32'd0 : INT_MIN;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        acc_nx  = acc;
        rem_sh  = acc[63:31];
        rem_sub = rem_sh[31:0] - mag_b;
        if (op_q[2]) begin
            if (rem_sh >= {1'b0, mag_b})
                acc_nx = {rem_sub, acc[30:0], 1'b1};
            else
                acc_nx = {rem_sh[31:0], acc[30:0], 1'b0};
        end else if (mag_b[cnt]) begin
            acc_nx = acc + ({32'd0, mag_a} << cnt);
        end
    end

    always_comb begin
        prod = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
        if (op_q[2]) begin
            if (op_q[1])
                fix_result = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
            else
                fix_result = (sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
        end else begin
            fix_result = (op_q == 3'b000) ? prod[31:0] : prod[63:32];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = fast ? DONE : BUSY;
            BUSY: if (cnt == 5'd31) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (EXU_MDU_result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (EXU_MDU_flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q                 <= 3'd0;
            sign_a               <= 1'b0;
            sign_b               <= 1'b0;
            mag_a                <= 32'd0;
            mag_b                <= 32'd0;
            acc                  <= 64'd0;
            cnt                  <= 5'd0;
            EXU_MDU_result       <= 32'd0;
            EXU_MDU_result_valid <= 1'b0;
        end else if (EXU_MDU_flush) begin
            cnt                  <= 5'd0;
            EXU_MDU_result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= EXU_MDU_op;
                    sign_a <= a_neg;
                    sign_b <= b_neg;
                    mag_a  <= mag_a_in;
                    mag_b  <= mag_b_in;
                    cnt    <= 5'd0;
                    acc    <= in_div ? {32'd0, mag_a_in} : 64'd0;
                    if (fast) begin
                        EXU_MDU_result       <= fast_result;
                        EXU_MDU_result_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    EXU_MDU_result       <= fix_result;
                    EXU_MDU_result_valid <= 1'b1;
                end
                DONE: if (EXU_MDU_result_ready) EXU_MDU_result_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_exu_mdu_ysyx_23060136.sv
`default_nettype none
// Directed-vector bench for exu_mdu_ysyx_23060136.
module tb_exu_mdu_ysyx_23060136;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exu_mdu_ysyx_23060136 dut (
        .clk                  (clk),
        .rst                  (rst),
        .EXU_MDU_valid        (valid),
        .EXU_MDU_ready        (ready),
        .EXU_MDU_op           (op),
        .EXU_HAZARD_rs1_data  (rs1),
        .EXU_HAZARD_rs2_data  (rs2),
        .EXU_MDU_flush        (flush),
        .EXU_MDU_result       (result),
        .EXU_MDU_result_valid (result_valid),
        .EXU_MDU_result_ready (result_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one request; returns just after the accept edge with garbage on the operand bus.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) check("ready_timeout", 32'd0, 32'd1);
        valid = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        valid = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    endtask

    // Counts edges after the accept edge until result_valid is seen (1 = already seen).
    task automatic wait_result(output int lat);
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(o, a, b);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, result, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        run("mul_neg",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run("mul_ones",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
        run("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run("mulhu",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
        run("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
        run("divu",       3'b101, 32'd100,      32'd7,        32'd14,        34);
        run("remu",       3'b111, 32'd100,      32'd7,        32'd2,         34);
        run("divu_big",   3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,        34);
        run("remu_big",   3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);
        run("div_zero",   3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run("remu_zero",  3'b111, 32'h1234,     32'd0,        32'h1234,      1);
        run("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

        // Backpressure
        result_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd5);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'd34);
        check("bp_result", result, 32'd15);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_result", result, 32'd15);
            check("bp_hold_valid", {31'd0, result_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, ready}, 32'd0);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after", {31'd0, ready}, 32'd1);
        check("bp_valid_after", {31'd0, result_valid}, 32'd0);
        run("bp_next", 3'b101, 32'd1000, 32'd10, 32'd100, 34);

        // Flush mid-divide
        issue(3'b100, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", {31'd0, ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // Flush concurrent with a request in IDLE
        valid = 1'b1; flush = 1'b1; op = 3'b101; rs1 = 32'd9; rs2 = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        check("flush_drop_ready", {31'd0, ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        check("flush_drop_no_valid", 32'(seen), 32'd0);

        // Asynchronous reset mid-multiply
        run("pre_rst", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);
        issue(3'b000, 32'd6, 32'd7);
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_result", result, 32'd0);
        check("arst_valid", {31'd0, result_valid}, 32'd0);
        check("arst_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("arst_ready_rel", {31'd0, ready}, 32'd1);
        run("post_rst", 3'b000, 32'd6, 32'd7, 32'd42, 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
